rps_client: RTL

RPS_CLIENT -- requirements
Module: rps_client

---
 rtl/rps_client_pkg.sv | 32 +++
 rtl/rps_client_job_cnt.sv | 46 ++++
 rtl/rps_client.sv | 115 +++++++++++
 3 files changed

// File: rtl/rps_client_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rps_client_pkg
// Purpose  : Shared types, constants and helpers for the rps_client slice.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package rps_client_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 3;
  localparam int IDX_W  = $clog2(NUM_CH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  function automatic logic is_onehot(input logic [NUM_CH-1:0] v);
    return ($countones(v) == 1);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_CH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rps_client_job_cnt.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : job_cnt
// Purpose  : Saturating per-channel pending-job counter with sticky overflow.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module job_cnt
  import rps_client_pkg::*;
#(
  parameter int PEND_MAX = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             sat_ovf
);

  localparam logic [CNT_W-1:0] c_pend_max = CNT_W'(PEND_MAX);

  logic [CNT_W-1:0] r_count;
  logic             r_sat_ovf;

  // Simultaneous inc and dec cancel, which also keeps a full counter full
  // without flagging overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count   <= '0;
      r_sat_ovf <= 1'b0;
    end else if (inc && !dec) begin
      if (r_count == c_pend_max) begin
        r_sat_ovf <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else if (dec && !inc) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count   = r_count;
  assign sat_ovf = r_sat_ovf;

endmodule
`default_nettype wire

// File: rtl/rps_client.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rps_client
// Purpose  : Client of a 4-way round-robin arbiter serving one job at a time.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rps_client
  import rps_client_pkg::*;
#(
  parameter int SERVICE_CYCLES = 2,
  parameter int PEND_MAX       = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] job,
  input  logic [NUM_CH-1:0] gnt,
  output logic [NUM_CH-1:0] req,
  output logic              en,
  output logic [NUM_CH-1:0] done,
  output logic              busy,
  output logic [NUM_CH-1:0] overflow,
  output logic              grant_err
);

  localparam logic [CNT_W-1:0] c_serve_last = CNT_W'(SERVICE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_owner_nxt;
  logic             r_grant_err;
  logic             w_grant_err_nxt;
  logic             w_accept;
  logic             w_gnt_legal;
  logic             w_last_cycle;
  logic [CNT_W-1:0] w_count [NUM_CH];

  assign w_gnt_legal = is_onehot(gnt) && ((gnt & req) == gnt);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_owner     <= '0;
      r_grant_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_owner     <= w_owner_nxt;
      r_grant_err <= w_grant_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_owner_nxt     = r_owner;
    w_grant_err_nxt = r_grant_err;
    w_accept        = 1'b0;
    w_last_cycle    = 1'b0;
    case (r_state)
      IDLE: begin
        if (gnt != '0) begin
          if (w_gnt_legal) begin
            w_accept    = 1'b1;
            w_owner_nxt = onehot_idx(gnt);
            w_timer_nxt = c_serve_last;
            w_state_nxt = SERVE;
          end else begin
            w_grant_err_nxt = 1'b1;
          end
        end
      end
      SERVE: begin
        if (gnt != '0) w_grant_err_nxt = 1'b1;
        // Timer counts the SERVE cycles still to come after this one.
        if (r_timer == '0) begin
          w_last_cycle = 1'b1;
          w_state_nxt  = IDLE;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Gated by reset so an aborted job never reports completion.
  always_comb begin
    done = '0;
    if (w_last_cycle && !reset) done[r_owner] = 1'b1;
  end

  assign en        = (r_state == IDLE);
  assign busy      = (r_state == SERVE);
  assign grant_err = r_grant_err;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    job_cnt #(
      .PEND_MAX (PEND_MAX)
    ) u_job_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc     (job[i]),
      .dec     (w_accept && gnt[i]),
      .count   (w_count[i]),
      .sat_ovf (overflow[i])
    );
    assign req[i] = (w_count[i] != '0);
  end

endmodule
`default_nettype wire
